// File: rtl/warp_mem_arbiter.sv
// warp_mem_arbiter: shares one memory port between fetch and load/store, one transaction in flight.
// Optional WARP_MEM_ARB_FAIRNESS_EN forces a fetch through after MAX_DATA_BURST data grants.
module warp_mem_arbiter #(
    parameter int MAX_DATA_BURST = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_imem_valid,
    input  logic [31:0] i_imem_addr,
    output logic        o_imem_ready,
    output logic        o_imem_rvalid,
    output logic [31:0] o_imem_rdata,
    input  logic        i_dmem_valid,
    input  logic [31:0] i_dmem_addr,
    input  logic        i_dmem_wen,
    input  logic [3:0]  i_dmem_wmask,
    input  logic [31:0] i_dmem_wdata,
    output logic        o_dmem_ready,
    output logic        o_dmem_rvalid,
    output logic [31:0] o_dmem_rdata,
    output logic        o_mem_valid,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wen,
    output logic [3:0]  o_mem_wmask,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t state;
    logic   owner_d;
    logic   force_i;
    logic   pick_i;
    logic   pick_d;

    if (MAX_DATA_BURST < 1 || MAX_DATA_BURST > 15) begin : g_bad_burst
        $error("MAX_DATA_BURST must be in 1..15");
    end

`ifdef WARP_MEM_ARB_FAIRNESS_EN
    logic [3:0] burst_cnt;

    always_comb force_i = (burst_cnt == 4'(MAX_DATA_BURST));

    // Counts data grants that starved a waiting fetch; saturates at 15.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            burst_cnt <= 4'd0;
        end else if (o_imem_ready) begin
            burst_cnt <= 4'd0;
        end else if (o_dmem_ready && i_imem_valid && burst_cnt != 4'hf) begin
            burst_cnt <= burst_cnt + 4'd1;
        end
    end
`else
    always_comb force_i = 1'b0;
`endif

    always_comb begin
        pick_i = i_imem_valid & (~i_dmem_valid | force_i);
        pick_d = i_dmem_valid & ~pick_i;
        // Gated by reset so every output reads 0 while reset is held.
        o_imem_ready = i_rst_n & (state == IDLE) & pick_i;
        o_dmem_ready = i_rst_n & (state == IDLE) & pick_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            owner_d       <= 1'b0;
            o_mem_valid   <= 1'b0;
            o_mem_addr    <= 32'd0;
            o_mem_wen     <= 1'b0;
            o_mem_wmask   <= 4'd0;
            o_mem_wdata   <= 32'd0;
            o_imem_rvalid <= 1'b0;
            o_imem_rdata  <= 32'd0;
            o_dmem_rvalid <= 1'b0;
            o_dmem_rdata  <= 32'd0;
        end else begin
            o_imem_rvalid <= 1'b0;
            o_dmem_rvalid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (o_imem_ready || o_dmem_ready) begin
                        owner_d     <= o_dmem_ready;
                        o_mem_valid <= 1'b1;
                        o_mem_addr  <= o_dmem_ready ? i_dmem_addr : i_imem_addr;
                        o_mem_wen   <= o_dmem_ready & i_dmem_wen;
                        o_mem_wmask <= o_dmem_ready ? i_dmem_wmask : 4'd0;
                        o_mem_wdata <= o_dmem_ready ? i_dmem_wdata : 32'd0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i_mem_ready) begin
                        o_mem_valid <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_mem_rvalid) begin
                        if (owner_d) begin
                            o_dmem_rvalid <= 1'b1;
                            o_dmem_rdata  <= i_mem_rdata;
                        end else begin
                            o_imem_rvalid <= 1'b1;
                            o_imem_rdata  <= i_mem_rdata;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
